tcm_loader: RTL

Boot-image loader that sits directly upstream of the simulation TCM and the RISC-V core. It consumes a byte stream (boot PC header, length header, payload), packs the payload into 32-bit little-endian words and writes them through the TCM data write port. While loading it holds the core in reset; on completion it presents the boot PC and releases the core. This replaces the testbench-side file preload, and the same path serves hardware bring-up.

---
 rtl/tcm_loader_if.sv | 35 +++
 rtl/tcm_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tcm_loader_if.sv
// tcm_loader bus bundle: boot byte stream, TCM write port, core boot control.
`timescale 1ns/1ps
interface tcm_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] mem_d_addr_o;
  logic [31:0] mem_d_data_wr_o;
  logic [3:0]  mem_d_wr_o;
  logic [10:0] mem_d_req_tag_o;
  logic        mem_d_accept_i;
  logic        mem_d_ack_i;
  logic        mem_d_error_i;
  logic [31:0] boot_pc_o;
  logic        core_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  modport master (
    input  byte_valid_i, byte_data_i,
    input  mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
    output byte_ready_o,
    output mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_req_tag_o,
    output boot_pc_o, core_rst_o, busy_o, done_o, error_o
  );

  modport slave (
    output byte_valid_i, byte_data_i,
    output mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
    input  byte_ready_o,
    input  mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_req_tag_o,
    input  boot_pc_o, core_rst_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/tcm_loader.sv
// Boot-image loader: byte stream -> LE words -> TCM writes, holds core in reset.
`timescale 1ns/1ps
module tcm_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 16,
  parameter int          MAX_OUT   = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tcm_loader_if.master bus
);

  localparam int              OW       = $clog2(MAX_OUT + 1);
  localparam int              CW       = ADDR_W + 1;
  localparam logic [32:0]     LEN_MAX  = 33'd1 << ADDR_W;
  localparam logic [OW-1:0]   OUT_FULL = OW'(MAX_OUT);

  typedef enum logic [2:0] {
    HDR_PC, HDR_LEN, DATA, DRAIN, DONE, ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    hcnt_q;
  logic [31:0]   pc_q;
  logic [23:0]   len_lo_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] bcnt_q;
  logic [31:0]   wbuf_q;
  logic [3:0]    wstrb_q;
  logic          pend_q;
  logic          last_q;
  logic [31:0]   rdata_q;
  logic [3:0]    rstrb_q;
  logic [31:0]   addr_q;
  logic [10:0]   tag_q;
  logic [OW-1:0] out_q, out_d;

  logic          rdy, xfer, full, req_on, acc, ack_v;
  logic          byte_last, issue, len_big, hdr_end;
  logic [1:0]    lane;
  logic [3:0]    lane_bit;
  logic [31:0]   lane_data;
  logic [31:0]   len_full;
  logic [CW-1:0] bcnt_inc;

  // Handshake qualification, lane placement and outstanding bookkeeping.
  always_comb begin
    lane      = bcnt_q[1:0];
    lane_bit  = 4'b0001 << lane;
    lane_data = {24'd0, bus.byte_data_i} << {lane, 3'b000};
    bcnt_inc  = bcnt_q + CW'(1);
    byte_last = bcnt_inc == len_q;
    len_full  = {bus.byte_data_i, len_lo_q};
    len_big   = {1'b0, len_full} > LEN_MAX;
    hdr_end   = hcnt_q == 2'd3;
    full      = out_q == OUT_FULL;
    req_on    = !rst_i && pend_q && !full && state_q != ERROR;
    rdy       = !rst_i && !pend_q &&
                (state_q == HDR_PC || state_q == HDR_LEN ||
                 state_q == DATA);
    xfer      = rdy && bus.byte_valid_i;
    issue     = state_q == DATA && xfer &&
                (lane == 2'd3 || byte_last);
    acc       = req_on && bus.mem_d_accept_i;
    ack_v     = bus.mem_d_ack_i && (out_q != '0 || acc);
    out_d     = out_q;
    if (acc && !ack_v)
      out_d = out_q + OW'(1);
    else if (!acc && ack_v)
      out_d = out_q - OW'(1);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= HDR_PC;
    else
      state_q <= state_d;
  end

  // Next-state decode; an error completion overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_PC:
        if (xfer && hdr_end)
          state_d = HDR_LEN;
      HDR_LEN:
        if (xfer && hdr_end) begin
          if (len_full == 32'd0)
            state_d = DONE;
          else if (len_big)
            state_d = ERROR;
          else
            state_d = DATA;
        end
      DATA:
        if (acc && last_q)
          state_d = (out_d == '0) ? DONE : DRAIN;
      DRAIN:
        if (out_d == '0)
          state_d = DONE;
      default: state_d = state_q;
    endcase
    if (ack_v && bus.mem_d_error_i)
      state_d = ERROR;
  end

  // Header capture, word packing and the single write holding register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q   <= '0;
      pc_q     <= '0;
      len_lo_q <= '0;
      len_q    <= '0;
      bcnt_q   <= '0;
      wbuf_q   <= '0;
      wstrb_q  <= '0;
      pend_q   <= 1'b0;
      last_q   <= 1'b0;
      rdata_q  <= '0;
      rstrb_q  <= '0;
      addr_q   <= '0;
      tag_q    <= '0;
      out_q    <= '0;
    end else begin
      out_q <= out_d;
      if (xfer && state_q == HDR_PC) begin
        pc_q[{hcnt_q, 3'b000} +: 8] <= bus.byte_data_i;
        hcnt_q <= hcnt_q + 2'd1;
      end
      if (xfer && state_q == HDR_LEN) begin
        hcnt_q <= hcnt_q + 2'd1;
        if (!hdr_end) begin
          len_lo_q[{hcnt_q, 3'b000} +: 8] <= bus.byte_data_i;
        end else begin
          len_q   <= len_full[CW-1:0];
          bcnt_q  <= '0;
          addr_q  <= BASE_ADDR;
          tag_q   <= '0;
          wbuf_q  <= '0;
          wstrb_q <= '0;
        end
      end
      if (xfer && state_q == DATA) begin
        bcnt_q <= bcnt_inc;
        if (issue) begin
          rdata_q <= wbuf_q | lane_data;
          rstrb_q <= wstrb_q | lane_bit;
          pend_q  <= 1'b1;
          last_q  <= byte_last;
          wbuf_q  <= '0;
          wstrb_q <= '0;
        end else begin
          wbuf_q  <= wbuf_q | lane_data;
          wstrb_q <= wstrb_q | lane_bit;
        end
      end
      if (acc) begin
        pend_q <= 1'b0;
        addr_q <= addr_q + 32'd4;
        tag_q  <= tag_q + 11'd1;
      end
    end
  end

  // Output decode; reset forces the idle/held-core view.
  always_comb begin
    bus.byte_ready_o    = rdy;
    bus.mem_d_addr_o    = addr_q;
    bus.mem_d_data_wr_o = rdata_q;
    bus.mem_d_wr_o      = req_on ? rstrb_q : 4'd0;
    bus.mem_d_req_tag_o = tag_q;
    bus.boot_pc_o       = pc_q;
    bus.busy_o          = 1'b0;
    bus.done_o          = 1'b0;
    bus.error_o         = 1'b0;
    bus.core_rst_o      = 1'b1;
    unique case (1'b1)
      (state_q == DONE): begin
        bus.done_o     = 1'b1;
        bus.core_rst_o = 1'b0;
      end
      (state_q == ERROR): bus.error_o = 1'b1;
      default: bus.busy_o = 1'b1;
    endcase
    if (rst_i) begin
      bus.busy_o     = 1'b0;
      bus.done_o     = 1'b0;
      bus.error_o    = 1'b0;
      bus.core_rst_o = 1'b1;
    end
  end

endmodule
